// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler
//   Shares one pipelined WIDTH-bit adder among NREQ requesters. A round-robin
//   arbiter grants at most one request per cycle and registers the operands
//   onto the adder inputs. A {valid, id} tag travels alongside the adder pipeline
//   so that each result can be returned to the requester that issued it.
//
//   Optional build macro: ADDER_SCHED_STATS_EN adds the grant_cnt and max_wait
//   statistics outputs.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready      per-requester issue handshake (ready is one-hot or zero)
//   req_a/req_b/req_cin      per-requester operands, requester i at [i*WIDTH +: WIDTH]
//   hold                     blocks new grants while high
//   add_a/add_b/add_cin      registered operands driven to the adder
//   add_sum/add_cout         adder result, valid LAT cycles after the operands
//   resp_valid/resp_id       result valid strobe and owning requester
//   resp_sum/resp_cout       adder result passed through
//   busy, inflight           operations in flight (flag and count)
//   grant_cnt, max_wait      (ADDER_SCHED_STATS_EN only) saturating statistics
module adder_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int LAT   = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    input  logic                  hold,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic                  resp_valid,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_sum,
    output logic                  resp_cout,
    output logic                  busy,
    output logic [3:0]            inflight
`ifdef ADDER_SCHED_STATS_EN
    ,
    output logic [15:0]           grant_cnt,
    output logic [7:0]            max_wait
`endif
);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             gnt_valid;
    logic [IDW-1:0]   gnt_id;
    int unsigned      idx;
    logic [WIDTH-1:0] add_a_q, add_b_q;
    logic             add_cin_q;
    logic             tag_v_q  [LAT+1];
    logic [IDW-1:0]   tag_id_q [LAT+1];
    logic [3:0]       inflight_q;

    // Search from ptr upward with wrap; iterating from the far end lets the
    // nearest valid requester overwrite any farther one.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        if (!hold) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx = (int'(ptr_q) + k) % NREQ;
                if (req_valid[idx]) begin
                    gnt_valid = 1'b1;
                    gnt_id    = IDW'(idx);
                end
            end
        end
    end

    assign req_ready = (gnt_valid && rst) ? (NREQ'(1) << gnt_id) : '0;
    assign ptr_d     = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_cin_q  <= 1'b0;
            inflight_q <= '0;
            for (int s = 0; s <= LAT; s++) begin
                tag_v_q[s]  <= 1'b0;
                tag_id_q[s] <= '0;
            end
        end else begin
            if (gnt_valid) begin
                ptr_q     <= ptr_d;
                add_a_q   <= req_a[gnt_id*WIDTH +: WIDTH];
                add_b_q   <= req_b[gnt_id*WIDTH +: WIDTH];
                add_cin_q <= req_cin[gnt_id];
            end
            tag_v_q[0]  <= gnt_valid;
            tag_id_q[0] <= gnt_id;
            for (int s = 1; s <= LAT; s++) begin
                tag_v_q[s]  <= tag_v_q[s-1];
                tag_id_q[s] <= tag_id_q[s-1];
            end
            // Bounded by LAT+1 by construction, so no wrap guard is needed.
            case ({gnt_valid, tag_v_q[LAT]})
                2'b10:   inflight_q <= inflight_q + 4'd1;
                2'b01:   inflight_q <= inflight_q - 4'd1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign add_cin    = add_cin_q;
    assign resp_valid = tag_v_q[LAT];
    assign resp_id    = tag_id_q[LAT];
    assign resp_sum   = add_sum;
    assign resp_cout  = add_cout;
    assign inflight   = inflight_q;
    assign busy       = (inflight_q != 4'd0);

`ifdef ADDER_SCHED_STATS_EN
    logic [15:0] grant_cnt_q;
    logic [7:0]  wait_q [NREQ];
    logic [7:0]  wait_d [NREQ];
    logic [7:0]  max_wait_q, max_wait_d;

    // A requester's wait restarts whenever it is accepted or drops valid.
    always_comb begin
        max_wait_d = max_wait_q;
        for (int i = 0; i < NREQ; i++) begin
            wait_d[i] = '0;
            if (req_valid[i] && !req_ready[i])
                wait_d[i] = (wait_q[i] == 8'hFF) ? wait_q[i] : wait_q[i] + 8'd1;
            if (wait_d[i] > max_wait_d)
                max_wait_d = wait_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt_q <= '0;
            max_wait_q  <= '0;
            for (int i = 0; i < NREQ; i++) wait_q[i] <= '0;
        end else begin
            if (gnt_valid && grant_cnt_q != 16'hFFFF)
                grant_cnt_q <= grant_cnt_q + 16'd1;
            max_wait_q <= max_wait_d;
            for (int i = 0; i < NREQ; i++) wait_q[i] <= wait_d[i];
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign max_wait  = max_wait_q;
`endif

endmodule

// File: tb/tb_adder_rr_scheduler.sv
module tb_adder_rr_scheduler;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int LAT   = 2;
    localparam int IDW   = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       v;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [NREQ-1:0]       req_cin;
    logic                  hold;
    logic [WIDTH-1:0]      add_a, add_b, add_sum;
    logic                  add_cin, add_cout;
    logic                  resp_valid, resp_cout, busy;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_sum;
    logic [3:0]            inflight;
`ifdef ADDER_SCHED_STATS_EN
    logic [15:0]           grant_cnt;
    logic [7:0]            max_wait;
`endif

    logic [WIDTH-1:0] ra [NREQ];
    logic [WIDTH-1:0] rb [NREQ];
    logic             rc [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        req_a   = '0;
        req_b   = '0;
        req_cin = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = ra[i];
            req_b[i*WIDTH +: WIDTH] = rb[i];
            req_cin[i]              = rc[i];
        end
    end

    // Adder model: LAT-cycle pipelined a+b+cin.
    logic [WIDTH:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= (WIDTH+1)'(add_a) + (WIDTH+1)'(add_b) + (WIDTH+1)'(add_cin);
        for (int s = 1; s < LAT; s++) apipe[s] <= apipe[s-1];
    end
    assign {add_cout, add_sum} = apipe[LAT-1];

    adder_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(v), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .hold(hold),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_sum(resp_sum), .resp_cout(resp_cout),
        .busy(busy), .inflight(inflight)
`ifdef ADDER_SCHED_STATS_EN
        , .grant_cnt(grant_cnt), .max_wait(max_wait)
`endif
    );

    // Reference model: every accepted op becomes a response due LAT+1 cycles later.
    typedef struct {
        int             due;
        int             id;
        logic [WIDTH:0] res;
    } resp_t;

    resp_t            rq[$];
    int               m_ptr;
    logic [WIDTH-1:0] m_a, m_b;
    logic             m_cin;
    int               cyc;
    int               n_chk;
    int               n_fail;
    int               peak;
    logic [NREQ-1:0]  last_rdy;
    logic [7:0]       last_resp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic new_op(input int i);
        ra[i] = WIDTH'($urandom);
        rb[i] = WIDTH'($urandom);
        rc[i] = 1'($urandom);
    endtask

    // Entered at posedge+1 with inputs set; checks at the falling edge.
    task automatic step();
        int              g;
        logic [NREQ-1:0] er;
        #4;
        g = -1;
        if (!hold)
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("inflight", inflight, rq.size());
        chk("busy", busy, rq.size() != 0);
        chk("add_ops", {add_cin, add_b, add_a}, {m_cin, m_b, m_a});
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("resp", {resp_valid, resp_id, resp_cout, resp_sum},
                {1'b1, IDW'(rq[0].id), rq[0].res});
            void'(rq.pop_front());
        end else begin
            chk("resp_valid", resp_valid, 0);
        end
        last_rdy  = req_ready;
        last_resp = {resp_valid, resp_id, resp_cout, resp_sum};
        if (int'(inflight) > peak) peak = int'(inflight);
        if (g >= 0) begin
            rq.push_back('{cyc + LAT + 1, g,
                (WIDTH+1)'(ra[g]) + (WIDTH+1)'(rb[g]) + (WIDTH+1)'(rc[g])});
            m_ptr = (g + 1) % NREQ;
            m_a   = ra[g];
            m_b   = rb[g];
            m_cin = rc[g];
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        rq.delete();
        m_ptr = 0;
        m_a   = '0;
        m_b   = '0;
        m_cin = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle with a requester still valid.
    task automatic do_reset();
        hold = 1'b0;
        rst  = 1'b0;
        #1;
        chk("rst_outs", {add_a, add_b, add_cin, resp_valid, resp_id, req_ready, busy, inflight},
            32'd0);
        v = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc++;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        peak   = 0;
        rst    = 1'b0;
        hold   = 1'b0;
        v      = '0;
        for (int i = 0; i < NREQ; i++) new_op(i);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {add_a, add_b, add_cin, resp_valid, resp_id, req_ready, busy, inflight},
            32'd0);
        rst = 1'b1;
        repeat (2) step();

        // Two ops in flight, then reset mid-stream; no stale response afterwards.
        v = 4'b0001;
        step();
        new_op(0);
        step();
        chk("pre_rst_inflight", inflight, 2);
        v = 4'b0001;
        do_reset();
        repeat (5) step();

        // Single op from requester 2.
        ra[2] = 4'h7; rb[2] = 4'h9; rc[2] = 1'b1;
        v = 4'b0100;
        step();
        chk("single_rdy", last_rdy, 4'b0100);
        v = '0;
        chk("single_add_a", add_a, 4'h7);
        repeat (3) step();
        chk("single_resp", last_resp, 8'b1_10_1_0001);

        // ptr is 3: only requester 1 valid -> grant 1, then {0,2} valid -> grant 2.
        v = 4'b0010;
        step();
        chk("wrap_g1", last_rdy, 4'b0010);
        v = 4'b0101;
        step();
        chk("skip_g2", last_rdy, 4'b0100);
        v = 4'b1000;
        step();
        chk("wrap_g3", last_rdy, 4'b1000);
        v = '0;
        repeat (4) step();

        // All valid from ptr 0: strict rotation, back-to-back responses.
        peak = 0;
        v = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            logic [NREQ-1:0] e;
            e = 4'b0001 << (k % NREQ);
            step();
            chk("rotation", last_rdy, e);
        end
        v = '0;
        repeat (4) step();
        chk("peak_inflight", peak, LAT + 1);

        // Three in flight, then hold for 4 cycles; they drain and grants resume at ptr.
        v = 4'b1111;
        repeat (3) step();
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("hold_rdy", last_rdy, 0);
        end
        chk("hold_drained", busy, 0);
        hold = 1'b0;
        step();
        chk("hold_resume", last_rdy, 4'b1000);
        v = '0;
        repeat (4) step();

        // Randomized traffic with random hold.
        for (int n = 0; n < 3000; n++) begin
            hold = ($urandom_range(0, 7) == 0);
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (last_rdy[i]) begin
                    v[i] = 1'($urandom_range(0, 1));
                    new_op(i);
                end else if (!v[i] && $urandom_range(0, 2) == 0) begin
                    v[i] = 1'b1;
                    new_op(i);
                end
            end
        end
        hold = 1'b0;
        v    = '0;
        repeat (5) step();
        chk("final_idle", inflight, 0);

`ifdef ADDER_SCHED_STATS_EN
        do_reset();
        v = 4'b1111;
        repeat (4) step();
        v = '0;
        step();
        chk("max_wait", max_wait, 3);
        chk("grant_cnt4", grant_cnt, 4);
        v = 4'b0010;
        repeat (70000) step();
        v = '0;
        repeat (4) step();
        chk("grant_sat", grant_cnt, 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
